// File: rtl/reg_ltc_bank.sv
// rtl/reg_ltc_bank.sv - AXI4-Lite bank of RW control registers and snapshot status latches
// Ports: ACLK/ARESETN clock and async active-low reset; S_AXI_* AXI4-Lite slave;
//   rw_out control register contents; ltc_in live status words; ltc_capture capture
//   strobe; ltc_captured one-cycle pulse after any capture.
module reg_ltc_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 4,
  parameter int NUM_LTC    = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]  rw_out,
  input  logic [NUM_LTC*DATA_WIDTH-1:0] ltc_in,
  input  logic                          ltc_capture,
  output logic                          ltc_captured
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W-1:0] LTC_LO   = IDX_W'(NUM_RW);
  localparam logic [IDX_W-1:0] LTC_HI   = IDX_W'(NUM_RW + NUM_LTC - 1);
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_RW + NUM_LTC);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rw_q  [NUM_RW];
  logic [DATA_WIDTH-1:0] rw_d  [NUM_RW];
  logic [DATA_WIDTH-1:0] ltc_q [NUM_LTC];
  logic [DATA_WIDTH-1:0] ltc_d [NUM_LTC];
  logic [15:0]           cnt_q, cnt_d, cnt_base;
  logic                  ovf_q, ovf_d, ovf_base;
  logic                  captured_q, captured_d;

  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  wr_fire, wr_rw, wr_ltc, wr_stat, wr_mapped;
  logic                  cap, clr;
  logic [DATA_WIDTH-1:0] status_word, rd_word;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign aw_idx    = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  // The write handshake completes at the edge that ends the one-cycle W_ACC state.
  assign wr_fire   = (w_state_q == W_ACC) && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_rw     = aw_idx < LTC_LO;
  assign wr_ltc    = (aw_idx >= LTC_LO) && (aw_idx <= LTC_HI);
  assign wr_stat   = aw_idx == STAT_IDX;
  assign wr_mapped = aw_idx <= STAT_IDX;
  // Hardware strobe and software command at the same edge merge into one event.
  assign cap       = ltc_capture || (wr_fire && wr_ltc);
  assign clr       = wr_fire && wr_stat;

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = W_ACC;
      W_ACC: begin
        if (wr_fire) begin
          w_state_d = W_RESP;
          bresp_d   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_RW; k++) begin
      rw_d[k] = rw_q[k];
      if (wr_fire && wr_rw && (aw_idx == IDX_W'(k))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (S_AXI_WSTRB[b]) rw_d[k][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LTC; k++) begin
      ltc_d[k] = cap ? ltc_in[k*DATA_WIDTH +: DATA_WIDTH] : ltc_q[k];
    end
    // Clear is applied before a coincident capture increments.
    cnt_base   = clr ? 16'h0 : cnt_q;
    ovf_base   = clr ? 1'b0 : ovf_q;
    cnt_d      = cnt_base;
    ovf_d      = ovf_base;
    if (cap) begin
      cnt_d = cnt_base + 16'h1;
      if (cnt_base == 16'hFFFF) ovf_d = 1'b1;
    end
    captured_d = cap;
  end

  always_comb begin
    status_word       = '0;
    status_word[15:0] = cnt_q;
    status_word[31]   = ovf_q;
    rd_word           = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (ar_idx == IDX_W'(k)) rd_word = rw_q[k];
    end
    for (int k = 0; k < NUM_LTC; k++) begin
      if (ar_idx == IDX_W'(NUM_RW + k)) rd_word = ltc_q[k];
    end
    if (ar_idx == STAT_IDX) rd_word = status_word;
  end

  // ARREADY is registered so it stays low until the first edge after reset release.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rdata_d   = rd_word;
          rresp_d   = (ar_idx <= STAT_IDX) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      captured_q <= 1'b0;
      for (int k = 0; k < NUM_RW; k++) rw_q[k] <= '0;
      for (int k = 0; k < NUM_LTC; k++) ltc_q[k] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      captured_q <= captured_d;
      for (int k = 0; k < NUM_RW; k++) rw_q[k] <= rw_d[k];
      for (int k = 0; k < NUM_LTC; k++) ltc_q[k] <= ltc_d[k];
    end
  end

  assign S_AXI_AWREADY = (w_state_q == W_ACC);
  assign S_AXI_WREADY  = (w_state_q == W_ACC);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ltc_captured  = captured_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_out[g*DATA_WIDTH +: DATA_WIDTH] = rw_q[g];
  end

endmodule

// File: tb/tb_reg_ltc_bank.sv
// tb/tb_reg_ltc_bank.sv - self-checking bench for reg_ltc_bank
module tb_reg_ltc_bank;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [7:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic [127:0] rw_out, ltc_in;
  logic         ltc_capture, ltc_captured;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  reg_ltc_bank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .rw_out(rw_out), .ltc_in(ltc_in), .ltc_capture(ltc_capture), .ltc_captured(ltc_captured)
  );

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic cap_at_hs, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("awready_wait", AWREADY, 1'b1);
    if (cap_at_hs) ltc_capture = 1'b1;
    @(negedge ACLK);
    ltc_capture = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid_after_hs", BVALID, 1'b1);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("arready_wait", ARREADY, 1'b1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("rvalid_after_hs", RVALID, 1'b1);
    data = RDATA;
    resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;

  initial begin
    vec[0]  = '{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,        2'b00};
    vec[1]  = '{1'b1, 8'h04, 32'h2,        4'hF, 32'h0,        2'b00};
    vec[2]  = '{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        2'b00};
    vec[3]  = '{1'b1, 8'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
    vec[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h1,        2'b00};
    vec[5]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        2'b00};
    vec[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vec[7]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
    vec[8]  = '{1'b1, 8'h00, 32'h0,        4'hF, 32'h0,        2'b00};
    vec[9]  = '{1'b1, 8'h00, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
    vec[10] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h00BB00DD, 2'b00};
    vec[11] = '{1'b0, 8'h24, 32'h0,        4'h0, 32'h0,        2'b10};
    vec[12] = '{1'b1, 8'h24, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
    vec[13] = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        2'b00};
    vec[14] = '{1'b0, 8'h06, 32'h0,        4'h0, 32'h2,        2'b00};
    vec[15] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h0,        2'b00};

    ARESETN = 1'b0;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WDATA = '0; WSTRB = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    ltc_in = '0; ltc_capture = 0;

    repeat (3) @(negedge ACLK);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rw_out", rw_out, '0);
    check("rst_captured", ltc_captured, 1'b0);
    ARESETN = 1'b1;
    #1 check("arready_before_edge", ARREADY, 1'b0);
    @(negedge ACLK);
    check("arready_after_edge", ARREADY, 1'b1);

    // Lone AWVALID must not be accepted.
    AWVALID = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check("lone_aw_awready", AWREADY, 1'b0);
    end
    AWVALID = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vec[i].wr) begin
        axi_write(vec[i].addr, vec[i].data, vec[i].strb, 1'b0, rs);
        check($sformatf("vec%0d_bresp", i), rs, vec[i].exp_resp);
      end else begin
        axi_read(vec[i].addr, rd, rs);
        check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), rs, vec[i].exp_resp);
      end
    end
    check("rw_out_after_table", rw_out, {32'h4, 32'h3, 32'h2, 32'h00BB00DD});

    // Hardware capture, then change live inputs.
    ltc_in = {32'h40, 32'h30, 32'h20, 32'h10};
    @(negedge ACLK);
    ltc_capture = 1'b1;
    @(negedge ACLK);
    ltc_capture = 1'b0;
    ltc_in = {32'h444, 32'h333, 32'h222, 32'h111};
    check("captured_pulse", ltc_captured, 1'b1);
    @(negedge ACLK);
    check("captured_single", ltc_captured, 1'b0);
    for (int k = 0; k < 4; k++) begin
      axi_read(8'(8'h10 + 4 * k), rd, rs);
      check($sformatf("latch%0d", k), rd, 32'(32'h10 * (k + 1)));
    end
    axi_read(8'h20, rd, rs);
    check("status_one", rd, 32'h1);

    // Clear, then same-edge hardware strobe and software capture count once.
    axi_write(8'h20, 32'hDEAD, 4'hF, 1'b0, rs);
    axi_read(8'h20, rd, rs);
    check("status_cleared", rd, 32'h0);
    axi_write(8'h14, 32'h0, 4'hF, 1'b1, rs);
    check("sw_cap_bresp", rs, 2'b00);
    axi_read(8'h20, rd, rs);
    check("status_same_edge", rd, 32'h1);
    axi_read(8'h10, rd, rs);
    check("latch0_reloaded", rd, 32'h111);

    // Drive count to 0xFFFF, then wrap.
    axi_write(8'h20, 32'h0, 4'hF, 1'b0, rs);
    @(negedge ACLK);
    ltc_capture = 1'b1;
    repeat (65535) @(negedge ACLK);
    ltc_capture = 1'b0;
    axi_read(8'h20, rd, rs);
    check("status_ffff", rd, 32'h0000FFFF);
    @(negedge ACLK);
    ltc_capture = 1'b1;
    @(negedge ACLK);
    ltc_capture = 1'b0;
    axi_read(8'h20, rd, rs);
    check("status_overflow", rd, 32'h80000000);
    axi_write(8'h20, 32'h0, 4'hF, 1'b1, rs);
    axi_read(8'h20, rd, rs);
    check("status_clear_and_cap", rd, 32'h1);
    axi_write(8'h20, 32'h0, 4'hF, 1'b0, rs);
    axi_read(8'h20, rd, rs);
    check("status_zero", rd, 32'h0);

    // Pending write response and read data with ready low; lone AWVALID behind it.
    @(negedge ACLK);
    AWADDR = 8'h08; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 8'h04; ARVALID = 1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("stall_awready_acc", AWREADY, 1'b1);
    @(negedge ACLK);
    WVALID = 1'b0;
    AWADDR = 8'h0C;
    check("stall_rw2", rw_out[64 +: 32], 32'h55);
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      check($sformatf("stall%0d_awready", c), AWREADY, 1'b0);
      check($sformatf("stall%0d_bvalid", c), BVALID, 1'b1);
      check($sformatf("stall%0d_rvalid", c), RVALID, 1'b1);
      check($sformatf("stall%0d_rdata", c), RDATA, 32'h2);
    end
    #2 ARESETN = 1'b0;
    #1;
    check("midrst_bvalid", BVALID, 1'b0);
    check("midrst_rvalid", RVALID, 1'b0);
    check("midrst_awready", AWREADY, 1'b0);
    check("midrst_arready", ARREADY, 1'b0);
    check("midrst_rw_out", rw_out, '0);
    AWVALID = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
